// File: rtl/orient_hist_pkg.sv
// Shared constants, FSM state type and saturating accumulate helper for the
// orientation-histogram accumulator.
package orient_hist_pkg;

  localparam int NORM     = 20;
  localparam int NBINS    = 36;
  localparam int ACCW     = 28;
  localparam int BW       = 6;
  localparam longint ANG_FULL = 64'd1 << NORM;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    SEARCH = 1'b1
  } state_t;

  function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] acc,
                                               input logic [NORM-1:0] mag);
    logic [ACCW:0] sum;
    sum = {1'b0, acc} + (ACCW+1)'(mag);
    return sum[ACCW] ? {ACCW{1'b1}} : sum[ACCW-1:0];
  endfunction

endpackage

// File: rtl/orient_hist_bin_map.sv
// Combinational angle-to-bin mapping: bin = (ang * NBINS) >> NORM.
module orient_bin_map
  import orient_hist_pkg::*;
(
  input  logic [NORM-1:0] ang,
  output logic [BW-1:0]   bin
);

  logic [NORM+BW-1:0] prod_s;

  // Product never exceeds (2^NORM-1)*NBINS, so the top BW bits stay below NBINS
  always_comb begin
    prod_s = {{BW{1'b0}}, ang} * (NORM+BW)'(NBINS);
    bin    = prod_s[NORM+BW-1:NORM];
  end

endmodule

// File: rtl/orient_hist.sv
// Orientation-histogram accumulator: bins CORDIC angle/magnitude samples per
// window, then scans for the dominant bin while clearing the histogram.
module orient_hist
  import orient_hist_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NORM-1:0] in_mag,
  input  logic [NORM-1:0] in_ang,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [BW-1:0]   out_bin,
  output logic [ACCW-1:0] out_peak,
  output logic            out_valid,
  output logic            err
);

  state_t          state_r, state_next_s;
  logic [ACCW-1:0] hist_r [NBINS];
  logic            s1_valid_r, s1_last_r;
  logic [BW-1:0]   s1_bin_r, bin_s;
  logic [NORM-1:0] s1_mag_r;
  logic [BW-1:0]   scan_idx_r, best_bin_r, cand_bin_s;
  logic [ACCW-1:0] best_peak_r, cand_peak_s;
  logic            search_done_s, accept_s;
  logic            in_ready_r, out_valid_r, err_r;
  logic [BW-1:0]   out_bin_r;
  logic [ACCW-1:0] out_peak_r;

  assign accept_s = in_valid & in_ready_r;

  orient_bin_map u_bin_map (
    .ang (in_ang),
    .bin (bin_s)
  );

  // S1: register accepted sample; magnitude MSB is forced to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_bin_r   <= {BW{1'b0}};
      s1_mag_r   <= {NORM{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_last_r <= in_last;
        s1_bin_r  <= bin_s;
        s1_mag_r  <= {1'b0, in_mag[NORM-2:0]};
      end
    end
  end

  // S2 accumulate during ACCUM, read-and-clear during SEARCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBINS; i++) hist_r[i] <= {ACCW{1'b0}};
    end else if (state_r == SEARCH) begin
      hist_r[scan_idx_r] <= {ACCW{1'b0}};
    end else if (s1_valid_r) begin
      hist_r[s1_bin_r] <= sat_add(hist_r[s1_bin_r], s1_mag_r);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ACCUM;
    else      state_r <= state_next_s;
  end

  // Next state and running-maximum candidate; bin 0 seeds the scan so ties keep the lowest index
  always_comb begin
    state_next_s  = state_r;
    search_done_s = 1'b0;
    cand_bin_s    = best_bin_r;
    cand_peak_s   = best_peak_r;
    case (state_r)
      ACCUM: begin
        if (s1_valid_r && s1_last_r) state_next_s = SEARCH;
        else                         state_next_s = ACCUM;
      end
      SEARCH: begin
        if (scan_idx_r == {BW{1'b0}} || hist_r[scan_idx_r] > best_peak_r) begin
          cand_bin_s  = scan_idx_r;
          cand_peak_s = hist_r[scan_idx_r];
        end else begin
          cand_bin_s  = best_bin_r;
          cand_peak_s = best_peak_r;
        end
        if (scan_idx_r == BW'(NBINS-1)) begin
          search_done_s = 1'b1;
          state_next_s  = ACCUM;
        end else begin
          state_next_s  = SEARCH;
        end
      end
      default: state_next_s = ACCUM;
    endcase
  end

  // Scan bookkeeping, result registers and handshake/error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_idx_r  <= {BW{1'b0}};
      best_bin_r  <= {BW{1'b0}};
      best_peak_r <= {ACCW{1'b0}};
      out_bin_r   <= {BW{1'b0}};
      out_peak_r  <= {ACCW{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      if (state_r == SEARCH) begin
        best_bin_r  <= cand_bin_s;
        best_peak_r <= cand_peak_s;
        scan_idx_r  <= search_done_s ? {BW{1'b0}} : scan_idx_r + BW'(1);
      end
      out_valid_r <= search_done_s;
      if (search_done_s) begin
        out_bin_r  <= cand_bin_s;
        out_peak_r <= cand_peak_s;
      end
      if (search_done_s)              in_ready_r <= 1'b1;
      else if (accept_s && in_last)   in_ready_r <= 1'b0;
      if (in_valid && !in_ready_r)    err_r <= 1'b1;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_bin   = out_bin_r;
  assign out_peak  = out_peak_r;
  assign out_valid = out_valid_r;
  assign err       = err_r;

endmodule

// File: tb/tb_orient_hist.sv
// Directed self-checking bench for orient_hist with hand-computed results.
module tb_orient_hist;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] in_mag = 20'd0;
  logic [19:0] in_ang = 20'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [5:0]  out_bin;
  logic [27:0] out_peak;
  logic        out_valid;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  orient_hist dut (
    .clk       (clk),
    .rst       (rst),
    .in_mag    (in_mag),
    .in_ang    (in_ang),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_bin   (out_bin),
    .out_peak  (out_peak),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] m, input logic [19:0] a, input logic l);
    in_mag = m; in_ang = a; in_last = l; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [5:0] eb,
                             input logic [27:0] ep, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_bin"},   32'(out_bin),   32'(eb));
    chk({tag, "_peak"},  32'(out_peak),  32'(ep));
    chk({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    repeat (3) step();
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bin",   32'(out_bin),   32'd0);
    chk("rst_peak",  32'(out_peak),  32'd0);
    chk("rst_err",   32'(err),       32'd0);

    // single sample at 90 degrees: bin 9, result 38 cycles after acceptance
    send(20'd100, 20'h40000, 1'b1);
    chk("single_notready", 32'(in_ready), 32'd0);
    wait_result("single", 6'd9, 28'd100, lat);
    chk("single_latency", 32'(lat), 32'd37);
    step();
    chk("single_pulse", 32'(out_valid), 32'd0);
    chk("single_hold_bin",  32'(out_bin),  32'd9);
    chk("single_hold_peak", 32'(out_peak), 32'd100);

    // tie between bin 1 and bin 20 goes to the lower index
    send(20'd50, 20'h08000, 1'b0);
    send(20'd50, 20'h90000, 1'b1);
    wait_result("tie", 6'd1, 28'd50, lat);

    // saturation: 600 * 0x7FFFF exceeds 2^28-1
    for (int i = 0; i < 600; i++) send(20'h7FFFF, 20'h00000, (i == 599));
    wait_result("sat", 6'd0, 28'hFFFFFFF, lat);

    // angle boundaries in back-to-back windows
    send(20'd7, 20'hFFFFF, 1'b1);
    wait_result("ang_top", 6'd35, 28'd7, lat);
    send(20'd3, 20'hE0000, 1'b1);
    wait_result("ang_m45", 6'd31, 28'd3, lat);

    // empty window
    step();
    send(20'd0, 20'h12345, 1'b1);
    wait_result("empty", 6'd0, 28'd0, lat);

    // drop during SEARCH
    step();
    send(20'd10, 20'h40000, 1'b1);
    repeat (5) step();
    chk("drop_err_before", 32'(err), 32'd0);
    in_mag = 20'd999; in_ang = 20'h00000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("drop_err", 32'(err), 32'd1);
    wait_result("drop_res", 6'd9, 28'd10, lat);
    send(20'd4, 20'h08000, 1'b1);
    wait_result("drop_next", 6'd1, 28'd4, lat);
    chk("drop_err_sticky", 32'(err), 32'd1);

    // reset mid-window
    step();
    send(20'd500, 20'h00000, 1'b0);
    send(20'd500, 20'h00000, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rstw_err", 32'(err), 32'd0);
    watch_no_valid("rstw_novalid", 50);
    send(20'd20, 20'h90000, 1'b1);
    wait_result("rstw_next", 6'd20, 28'd20, lat);

    // reset mid-SEARCH
    step();
    send(20'd300, 20'h00000, 1'b1);
    repeat (10) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rsts_ready", 32'(in_ready), 32'd1);
    watch_no_valid("rsts_novalid", 50);
    send(20'd6, 20'hFFFFF, 1'b1);
    wait_result("rsts_next", 6'd35, 28'd6, lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/orient_hist.md
# orient_hist

Orientation-histogram accumulator for SIFT keypoint orientation assignment. It sits directly downstream of the CORDIC vectoring core and consumes its magnitude/angle stream (one gradient sample per valid cycle). Per keypoint window it bins each angle into NBINS sectors and accumulates the magnitude into that bin. After the window's last sample it scans the histogram, reports the dominant bin and its weight, and clears the histogram for the next window.

## Interface
- NORM, 20, width of magnitude and angle inputs; full circle = 2^NORM angle units
- NBINS, 36, number of orientation bins
- ACCW, 28, bin accumulator width
- BW, 6, bin index width, ceil(log2(NBINS))
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset: asynchronous and active-low; single clock domain
- in_mag  in  NORM  gradient magnitude, unsigned; MSB set is treated as 0
- in_ang  in  NORM  angle, taken modulo 2^NORM as unsigned
- in_valid  in  1  sample strobe
- in_last  in  1  marks the final sample of a window; qualified by in_valid
- in_ready  out  1  high while accepting samples
- out_bin  out  BW  dominant bin index
- out_peak  out  ACCW  accumulated weight of the dominant bin
- out_valid  out  1  one-cycle result strobe
- err  out  1  sticky flag: a sample arrived while in_ready=0

## Operation
- States: ACCUM, SEARCH. Reset enters ACCUM.
- Reset values: all histogram bins 0; in_ready=1; out_valid=0; out_bin=0; out_peak=0; err=0.
- Accepted sample: in_valid & in_ready.
- Stage S1 registers the sample: bin = (in_ang*NBINS) >> NORM, giving 0..NBINS-1. It also registers mag and last.
- Stage S2 adds mag to hist[bin]. The sum saturates at 2^ACCW-1.
- The histogram is a register array, so back-to-back samples to the same bin need no forwarding.
- An accepted sample with in_last=1 deasserts in_ready on the next edge. The FSM goes to SEARCH once S2 has written that sample.
- SEARCH lasts NBINS cycles and reads bins 0..NBINS-1 in order.
  - A bin replaces the running best only if it is strictly greater, so ties go to the lowest index.
  - Each bin is written to 0 in the cycle it is read.
- At the end of SEARCH the block registers out_bin/out_peak, pulses out_valid for 1 cycle, reasserts in_ready in the same cycle, and returns to ACCUM.
- out_bin/out_peak hold their value until the next result.
- Empty window (in_last on the first sample, mag 0): result is bin 0, peak 0.
- in_valid while in_ready=0: the sample is dropped and err is set. err clears only on reset.
- Reset mid-window or mid-SEARCH: the histogram is cleared immediately. No out_valid is produced for the aborted window.

## Timing
- Sample accepted at cycle T: its bin is updated at the end of T+1.
- in_last accepted at T:
  - in_ready=0 from T+1.
  - SEARCH occupies T+2..T+NBINS+1.
  - out_valid and in_ready=1 at T+NBINS+2 (T+38 at default).
- The next window may start in the out_valid cycle.
- Throughput: one sample per cycle inside a window. Dead time between windows is NBINS+1 cycles.

## Structure
- Shared package holds: NBINS, NORM, the angle full-scale constant 2^NORM, the state enum {ACCUM, SEARCH}, and the saturating-add function.
- One sub-module, orient_bin_map: combinational angle-to-bin multiply and shift, registered in S1 by the parent.

## Test plan
- Reset, then idle → in_ready=1, out_valid=0, out_bin=0, out_peak=0, err=0.
- Single sample mag=100, ang=0x40000 (90°), last=1 → 38 cycles later out_valid=1, out_bin=9, out_peak=100.
- Tie: mag=50 at ang 0x08000 (bin 1), mag=50 at ang 0x90000 (bin 20, last) → out_bin=1, out_peak=50.
- Saturation: 600 samples mag=0x7FFFF, ang=0 (bin 0) → out_bin=0, out_peak=0xFFFFFFF.
- Angle boundaries: ang 0xFFFFF → bin 35; ang 0xE0000 (−45°) → bin 31. Two windows sent back-to-back with single samples mag 7 and mag 3 → results 7 and 3. This proves the histogram is cleared between windows.
- Drop: in_valid pulsed during SEARCH → err=1, that window's result is unchanged, and the next window's histogram is unaffected. Asserting rst mid-window → no out_valid, and the next window's result contains only its own samples.
